uar_rx: RTL and testbench
=========================

Name: uar_rx

Overview:
- UART receive deserialiser for 8-bit frames, optional parity, one stop bit; idle line is high.
- Sits directly downstream of the RX synchroniser and consumes its already-synchronised serial line.
- Delivers bytes to the AXI-side register/FIFO logic over a valid/ready handshake.
- Bit timing comes from a runtime divisor so software can change the baud rate.

Parameters:
DIV_W, 16, width of the baud divisor input and the internal bit-timing counter

Ports:
Clk  input  1  system clock
Rst_n  input  1  asynchronous active-low reset
RxIn  input  1  synchronised serial line (idle high)
BaudDiv  input  DIV_W  clocks per bit; legal values 4..2^DIV_W-1; sampled only in IDLE
ParityEn  input  1  1 = parity bit expected after bit 7; sampled only in IDLE
ParityOdd  input  1  1 = odd parity, 0 = even; sampled only in IDLE
RxData  output  8  received byte; valid while RxValid=1
RxValid  output  1  byte available
RxReady  input  1  consumer accepts byte when RxValid & RxReady
FrameErr  output  1  stop bit sampled low; qualified by RxValid
ParityErr  output  1  parity mismatch; qualified by RxValid; 0 when ParityEn=0
OverrunErr  output  1  one-cycle pulse: completed frame dropped because RxValid still high
Busy  output  1  FSM not in IDLE

Behaviour:
- Reset (async, Rst_n=0): FSM in IDLE, counters cleared. RxData=0, RxValid=0, FrameErr=0, ParityErr=0, OverrunErr=0, Busy=0. Deassertion needs no special sequencing.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE:
  - Latch BaudDiv, ParityEn and ParityOdd into shadow registers.
  - RxIn=0 seen on cycle T0 -> START; bit counter loads BaudDiv>>1.
- Sampling instants, all relative to T0. Sample k is taken on the cycle the counter reaches 0; the counter then reloads shadow BaudDiv-1.
  - START sample: T0+(BaudDiv>>1). RxIn=1 -> false start, return to IDLE, no output. RxIn=0 -> DATA.
  - DATA bit n (n=0..7, LSB first): T0+(BaudDiv>>1)+(n+1)*BaudDiv. After n=7 -> PARITY if ParityEn else STOP.
  - PARITY sample: T0+(BaudDiv>>1)+9*BaudDiv. Mismatch against the XOR of the data bits (inverted for odd) sets the error.
  - STOP sample: one BaudDiv after the last data or parity sample.
- Frame completion, on the cycle after the STOP sample:
  - If RxValid=0: load RxData, set FrameErr=(stop==0) and ParityErr, and set RxValid=1.
  - If RxValid=1: keep old data and flags, pulse OverrunErr for exactly 1 cycle, discard the new frame.
- After the STOP sample:
  - Stop=1 -> IDLE.
  - Stop=0 -> WAIT_IDLE, which stays there until RxIn=1 (break/framing recovery), then -> IDLE. This prevents a held-low line from retriggering.
- Handshake:
  - RxValid, RxData and the error flags are stable until RxValid & RxReady.
  - On that cycle RxValid clears on the next edge.
  - If a completion and an accept occur on the same cycle, the new byte is loaded and RxValid stays 1; no overrun is reported.
- Busy=1 in every state except IDLE.
- BaudDiv, ParityEn and ParityOdd changes during a frame have no effect until the next IDLE.
- RxReady has no effect on reception timing.
- Reset mid-frame aborts immediately. The partial byte is lost and nothing is output.

Test Plan:
1. BaudDiv=16, ParityEn=0, send 0xA5 with stop=1 -> RxValid rises on cycle T0+8+9*16+1; RxData=0xA5, FrameErr=0, ParityErr=0; RxReady=1 clears RxValid next cycle.
2. BaudDiv=16, ParityEn=1, ParityOdd=0, send 0x03 with parity bit 1 -> ParityErr=1, RxData=0x03; repeat with parity bit 0 -> ParityErr=0.
3. Send 0x55 with stop=0 and hold RxIn low 40 cycles -> RxValid=1, FrameErr=1; no new frame starts until RxIn returns high; the next frame 0x12 is received correctly.
4. RxIn low pulse of 5 cycles with BaudDiv=16 -> false start; Busy returns to 0 with no RxValid.
5. RxReady=0, send 0x11 then 0x22 -> RxData stays 0x11; OverrunErr pulses 1 cycle at 0x22 completion; then RxReady=1 with a third frame 0x33 completing on the accept cycle -> RxData=0x33, RxValid stays 1, no overrun.
6. Assert Rst_n=0 during DATA bit 4 of frame 0xFF -> all outputs 0 immediately; after release, frame 0x81 is received correctly at BaudDiv=4 (minimum).

Source files
------------

// File: rtl/uar_rx.sv
// uar_rx: UART receive deserialiser. 8 data bits LSB first, optional parity,
// one stop bit, idle-high line. Bit timing comes from a runtime divisor that
// is captured while idle, so software may retune the baud rate between frames.
// Received bytes are offered on a valid/ready handshake with per-byte flags.
module uar_rx #(
  parameter int DIV_W = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             RxIn,
  input  logic [DIV_W-1:0] BaudDiv,
  input  logic             ParityEn,
  input  logic             ParityOdd,
  output logic [7:0]       RxData,
  output logic             RxValid,
  input  logic             RxReady,
  output logic             FrameErr,
  output logic             ParityErr,
  output logic             OverrunErr,
  output logic             Busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } state_t;

  localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic [DIV_W-1:0] bit_cnt;
  logic [DIV_W-1:0] div_q;
  logic             par_en_q;
  logic             par_odd_q;
  logic             par_err;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_q;
  logic             sample;

  // A bit is sampled on the cycle the timing counter has run down to zero.
  assign sample = (bit_cnt == '0);

  // Busy simply reflects that a frame (or break recovery) is in progress.
  assign Busy = (state != IDLE);

  // Receive FSM, bit timing, shift register and output handshake in one place
  // so that the completion/accept interaction is resolved in a single step.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      div_q      <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      par_err    <= 1'b0;
      bit_idx    <= 3'd0;
      shift_q    <= 8'h00;
      RxData     <= 8'h00;
      RxValid    <= 1'b0;
      FrameErr   <= 1'b0;
      ParityErr  <= 1'b0;
      OverrunErr <= 1'b0;
    end else begin
      OverrunErr <= 1'b0;
      if (RxValid && RxReady) begin
        RxValid <= 1'b0;
      end

      case (state)
        IDLE: begin
          div_q     <= BaudDiv;
          par_en_q  <= ParityEn;
          par_odd_q <= ParityOdd;
          if (!RxIn) begin
            // Loading half-divisor minus one puts the start sample exactly
            // half a bit after the falling edge was first seen.
            bit_cnt <= (BaudDiv >> 1) - ONE;
            par_err <= 1'b0;
            state   <= START;
          end
        end

        START: begin
          if (sample) begin
            if (RxIn) begin
              state <= IDLE;
            end else begin
              bit_cnt <= div_q - ONE;
              bit_idx <= 3'd0;
              state   <= DATA;
            end
          end else begin
            bit_cnt <= bit_cnt - ONE;
          end
        end

        DATA: begin
          if (sample) begin
            shift_q <= {RxIn, shift_q[7:1]};
            bit_cnt <= div_q - ONE;
            if (bit_idx == 3'd7) begin
              state <= par_en_q ? PARITY : STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            bit_cnt <= bit_cnt - ONE;
          end
        end

        PARITY: begin
          if (sample) begin
            par_err <= RxIn ^ (^shift_q) ^ par_odd_q;
            bit_cnt <= div_q - ONE;
            state   <= STOP;
          end else begin
            bit_cnt <= bit_cnt - ONE;
          end
        end

        STOP: begin
          if (sample) begin
            // A same-cycle accept frees the holding register, so the new
            // byte replaces the old one and RxValid stays high.
            if (!RxValid || RxReady) begin
              RxData    <= shift_q;
              FrameErr  <= ~RxIn;
              ParityErr <= par_en_q & par_err;
              RxValid   <= 1'b1;
            end else begin
              OverrunErr <= 1'b1;
            end
            state <= RxIn ? IDLE : WAIT_IDLE;
          end else begin
            bit_cnt <= bit_cnt - ONE;
          end
        end

        WAIT_IDLE: begin
          if (RxIn) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uar_rx.sv
// tb_uar_rx: directed testbench for uar_rx. A table of frames with
// hand-computed results drives the main checks; break handling, false start,
// overrun, same-cycle accept and mid-frame reset are hand-written sequences.
module tb_uar_rx;

  logic        Clk;
  logic        Rst_n;
  logic        RxIn;
  logic [15:0] BaudDiv;
  logic        ParityEn;
  logic        ParityOdd;
  logic [7:0]  RxData;
  logic        RxValid;
  logic        RxReady;
  logic        FrameErr;
  logic        ParityErr;
  logic        OverrunErr;
  logic        Busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t0       = 0;
  int rise_cyc = -1;
  int ovr_cycles = 0;
  logic prev_valid = 1'b0;

  typedef struct {
    int         div;
    logic [7:0] data;
    logic       pen;
    logic       podd;
    logic       pbit;
    logic       exp_perr;
    int         exp_lat;
  } vec_t;

  vec_t vecs [7];

  uar_rx #(.DIV_W(16)) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .RxIn       (RxIn),
    .BaudDiv    (BaudDiv),
    .ParityEn   (ParityEn),
    .ParityOdd  (ParityOdd),
    .RxData     (RxData),
    .RxValid    (RxValid),
    .RxReady    (RxReady),
    .FrameErr   (FrameErr),
    .ParityErr  (ParityErr),
    .OverrunErr (OverrunErr),
    .Busy       (Busy)
  );

  // 10 ns system clock.
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Edge counter used to time-stamp the start edge and the RxValid rise.
  always @(posedge Clk) begin
    cyc++;
  end

  // Record which edge raised RxValid and how many cycles OverrunErr was high.
  always @(negedge Clk) begin
    if (RxValid === 1'b1 && prev_valid !== 1'b1) rise_cyc = cyc;
    prev_valid = RxValid;
    if (OverrunErr === 1'b1) ovr_cycles++;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_cycles(input int n);
    RxIn = 1'b1;
    repeat (n) @(negedge Clk);
  endtask

  // Drives one frame starting now (called on a negedge); leaves RxIn at the
  // stop level after a full stop-bit period.
  task automatic apply_stimulus(input logic [7:0] d, input logic pen, input logic pbit,
                                input logic stop, input int div);
    RxIn = 1'b0;
    t0 = cyc + 1;
    repeat (div) @(negedge Clk);
    for (int i = 0; i < 8; i++) begin
      RxIn = d[i];
      repeat (div) @(negedge Clk);
    end
    if (pen) begin
      RxIn = pbit;
      repeat (div) @(negedge Clk);
    end
    RxIn = stop;
    repeat (div) @(negedge Clk);
  endtask

  task automatic accept_byte(input string name);
    RxReady = 1'b1;
    @(negedge Clk);
    RxReady = 1'b0;
    check_output({name, " valid cleared"}, 32'(RxValid), 32'd0);
  endtask

  initial begin
    int ovr_base;

    // div, data, pen, podd, pbit, expected ParityErr, expected RxValid latency
    vecs[0] = '{16, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 152};
    vecs[1] = '{16, 8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 168};
    vecs[2] = '{16, 8'h03, 1'b1, 1'b0, 1'b0, 1'b0, 168};
    vecs[3] = '{12, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 126};
    vecs[4] = '{12, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 126};
    vecs[5] = '{ 5, 8'hC8, 1'b1, 1'b0, 1'b0, 1'b1,  52};
    vecs[6] = '{ 7, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b0,  66};

    Rst_n = 1'b0;
    RxIn = 1'b1;
    BaudDiv = 16'd16;
    ParityEn = 1'b0;
    ParityOdd = 1'b0;
    RxReady = 1'b0;
    repeat (3) @(negedge Clk);
    check_output("reset RxValid", 32'(RxValid), 32'd0);
    check_output("reset RxData", 32'(RxData), 32'd0);
    check_output("reset Busy", 32'(Busy), 32'd0);
    check_output("reset errs", {29'd0, FrameErr, ParityErr, OverrunErr}, 32'd0);
    Rst_n = 1'b1;
    idle_cycles(3);

    // Table of frames, each accepted after completion.
    for (int v = 0; v < 7; v++) begin
      BaudDiv   = 16'(vecs[v].div);
      ParityEn  = vecs[v].pen;
      ParityOdd = vecs[v].podd;
      idle_cycles(2);
      apply_stimulus(vecs[v].data, vecs[v].pen, vecs[v].pbit, 1'b1, vecs[v].div);
      idle_cycles(2);
      $display("[TB] vector %0d data 0x%0h", v, vecs[v].data);
      check_output("vec RxValid", 32'(RxValid), 32'd1);
      check_output("vec RxData", 32'(RxData), 32'(vecs[v].data));
      check_output("vec FrameErr", 32'(FrameErr), 32'd0);
      check_output("vec ParityErr", 32'(ParityErr), 32'(vecs[v].exp_perr));
      check_output("vec latency", 32'(rise_cyc - t0), 32'(vecs[v].exp_lat));
      check_output("vec Busy", 32'(Busy), 32'd0);
      accept_byte("vec");
    end

    // Stop bit low with the line held low: frame error, then break recovery.
    BaudDiv = 16'd16;
    ParityEn = 1'b0;
    idle_cycles(2);
    apply_stimulus(8'h55, 1'b0, 1'b0, 1'b0, 16);
    check_output("break RxValid", 32'(RxValid), 32'd1);
    check_output("break RxData", 32'(RxData), 32'h55);
    check_output("break FrameErr", 32'(FrameErr), 32'd1);
    repeat (24) @(negedge Clk);
    check_output("break held Busy", 32'(Busy), 32'd1);
    check_output("break held data", 32'(RxData), 32'h55);
    RxIn = 1'b1;
    repeat (2) @(negedge Clk);
    check_output("break released Busy", 32'(Busy), 32'd0);
    accept_byte("break");
    idle_cycles(2);
    apply_stimulus(8'h12, 1'b0, 1'b0, 1'b1, 16);
    idle_cycles(2);
    check_output("after break RxData", 32'(RxData), 32'h12);
    check_output("after break FrameErr", 32'(FrameErr), 32'd0);
    accept_byte("after break");

    // False start: 5-cycle low pulse at divisor 16.
    RxIn = 1'b0;
    repeat (5) @(negedge Clk);
    RxIn = 1'b1;
    check_output("false start Busy high", 32'(Busy), 32'd1);
    repeat (8) @(negedge Clk);
    check_output("false start Busy low", 32'(Busy), 32'd0);
    check_output("false start RxValid", 32'(RxValid), 32'd0);

    // Overrun: second frame dropped while the first is still pending.
    ovr_base = ovr_cycles;
    idle_cycles(2);
    apply_stimulus(8'h11, 1'b0, 1'b0, 1'b1, 16);
    idle_cycles(2);
    check_output("ovr first RxData", 32'(RxData), 32'h11);
    apply_stimulus(8'h22, 1'b0, 1'b0, 1'b1, 16);
    idle_cycles(2);
    check_output("ovr kept RxData", 32'(RxData), 32'h11);
    check_output("ovr RxValid", 32'(RxValid), 32'd1);
    check_output("ovr pulse cycles", 32'(ovr_cycles - ovr_base), 32'd1);

    // Third frame completes on the very cycle the pending byte is accepted.
    fork
      apply_stimulus(8'h33, 1'b0, 1'b0, 1'b1, 16);
      begin
        repeat (8 + 9 * 16) @(negedge Clk);
        RxReady = 1'b1;
        @(negedge Clk);
        RxReady = 1'b0;
      end
    join
    check_output("same-cycle RxValid", 32'(RxValid), 32'd1);
    check_output("same-cycle RxData", 32'(RxData), 32'h33);
    check_output("same-cycle no overrun", 32'(ovr_cycles - ovr_base), 32'd1);

    // Reset during data bit 4 of 0xFF, with 0x33 still pending.
    idle_cycles(2);
    RxIn = 1'b0;
    repeat (16) @(negedge Clk);
    RxIn = 1'b1;
    repeat (4 * 16 + 8) @(negedge Clk);
    check_output("pre-reset Busy", 32'(Busy), 32'd1);
    #1;
    Rst_n = 1'b0;
    #1;
    check_output("mid reset RxValid", 32'(RxValid), 32'd0);
    check_output("mid reset RxData", 32'(RxData), 32'd0);
    check_output("mid reset Busy", 32'(Busy), 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    BaudDiv = 16'd4;
    idle_cycles(3);
    apply_stimulus(8'h81, 1'b0, 1'b0, 1'b1, 4);
    idle_cycles(2);
    check_output("div4 RxValid", 32'(RxValid), 32'd1);
    check_output("div4 RxData", 32'(RxData), 32'h81);
    check_output("div4 latency", 32'(rise_cyc - t0), 32'd38);
    check_output("div4 errs", {30'd0, FrameErr, ParityErr}, 32'd0);
    accept_byte("div4");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
